// File: rtl/kpn_arith_node.sv
// kpn_arith_node: two-input, one-output Kahn process node.
// Pops one token from each input FIFO together and applies the op chosen by
// op_sel (add, sub, mult, unsigned max). The result goes to the output FIFO
// through empty/full handshakes, so no token is lost and a full FIFO is never
// written. A token takes three cycles: IDLE (pop), CALC, then WRITE (push).
// Optional build macro KPN_SAT_EN: add, sub and mult saturate instead of
// wrapping, and a sat_flag output marks each clamped result.
module kpn_arith_node #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entry_1,
    input  logic             entry_1_empty,
    output logic             rd_1,
    input  logic [WIDTH-1:0] entry_2,
    input  logic             entry_2_empty,
    output logic             rd_2,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] output_1,
    input  logic             output_full,
    output logic             wr,
`ifdef KPN_SAT_EN
    output logic [CNT_W-1:0] tokens_out,
    output logic             sat_flag
`else
    output logic [CNT_W-1:0] tokens_out
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAX} op_t;

    state_t           state, state_nxt;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] calc_res;

`ifdef KPN_SAT_EN
    logic               calc_sat;
    logic [WIDTH:0]     sum_ext;
    logic [2*WIDTH-1:0] prod_ext;

    // Saturating datapath: clamp on carry-out, borrow or a non-zero upper product half
    always_comb begin
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        prod_ext = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        calc_res = '0;
        calc_sat = 1'b0;
        case (op_q)
            OP_ADD: begin
                calc_sat = sum_ext[WIDTH];
                calc_res = calc_sat ? '1 : sum_ext[WIDTH-1:0];
            end
            OP_SUB: begin
                calc_sat = (a_q < b_q);
                calc_res = calc_sat ? '0 : a_q - b_q;
            end
            OP_MUL: begin
                calc_sat = |prod_ext[2*WIDTH-1:WIDTH];
                calc_res = calc_sat ? '1 : prod_ext[WIDTH-1:0];
            end
            default: calc_res = (a_q >= b_q) ? a_q : b_q;
        endcase
    end
`else
    // Modulo 2^WIDTH datapath: sum, difference and product keep their low WIDTH bits
    always_comb begin
        calc_res = '0;
        case (op_q)
            OP_ADD:  calc_res = a_q + b_q;
            OP_SUB:  calc_res = a_q - b_q;
            OP_MUL:  calc_res = a_q * b_q;
            default: calc_res = (a_q >= b_q) ? a_q : b_q;
        endcase
    end
`endif

    // Next-state logic and handshake strobes. Reset gates every strobe, because
    // a synchronous reset leaves the state register untouched until the edge.
    always_comb begin
        // NOTE: every signal gets a default before the case statement; a path
        // that leaves one unassigned would infer a latch.
        state_nxt = state;
        rd_1      = 1'b0;
        rd_2      = 1'b0;
        wr        = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!entry_1_empty && !entry_2_empty) begin
                        rd_1      = 1'b1;
                        rd_2      = 1'b1;
                        state_nxt = CALC;
                    end
                end
                CALC: state_nxt = WRITE;
                WRITE: begin
                    if (!output_full) begin
                        wr        = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register, operand latch at the pop, result register in CALC, push counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values it saw before the edge.
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            output_1   <= '0;
            tokens_out <= '0;
`ifdef KPN_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (rd_1) begin
                a_q  <= entry_1;
                b_q  <= entry_2;
                op_q <= op_t'(op_sel);
            end
            if (state == CALC) begin
                output_1 <= calc_res;
`ifdef KPN_SAT_EN
                sat_flag <= calc_sat;
`endif
            end
            if (wr) begin
                tokens_out <= tokens_out + CNT_W'(1);
            end
        end
    end

endmodule
